// File: rtl/ad7606_cap_sched.sv
// AD7606 capture scheduler: paces conversion/seek pulses at a programmed period.
// Optional packet watchdog is enabled with `define CAP_TIMEOUT_EN.
module ad7606_cap_sched #(
  parameter int PERIOD_MIN  = 200,
  parameter int TIMEOUT_CYC = 4096,
  parameter int FRAME_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_valid,
  input  logic [7:0]         i_cfg_chnnel_num,
  input  logic [31:0]        i_cfg_period,
  input  logic [FRAME_W-1:0] i_cfg_frames,
  input  logic               i_start,
  input  logic               i_stop,
  output logic               o_conv_req,
  output logic               o_cap_seek,
  output logic [7:0]         o_cap_chnnel_num,
  input  logic               i_pkt_last,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_cfg_err,
  output logic               o_overrun,
  output logic [FRAME_W-1:0] o_frame_cnt,
  output logic               o_err_timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TRIG = 2'd1;
  localparam logic [1:0] S_WPKT = 2'd2;
  localparam logic [1:0] S_WPER = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [31:0]        r_period;
  logic [31:0]        r_per_cnt;
  logic [FRAME_W-1:0] r_frames;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [FRAME_W-1:0] w_cnt_inc;
  logic [7:0]         r_ch;
  logic               r_stop_pend;
  logic               r_trig;
  logic               r_busy;
  logic               r_done;
  logic               r_cfg_err;
  logic               r_overrun;
  logic               w_stop;
  logic               w_done;
  logic               w_ovr;
  logic               w_wd_hit;
  logic               w_go;

  assign w_stop    = r_stop_pend | i_stop;
  assign w_cnt_inc = r_frame_cnt + FRAME_W'(1);
  assign w_go      = (r_state == S_IDLE) && i_start && !i_stop;

  // Next-state decision and one-shot event flags
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_ovr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) w_next = S_TRIG;
      end
      S_TRIG: begin
        if (w_stop) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end else begin
          w_next = S_WPKT;
        end
      end
      S_WPKT: begin
        if (i_pkt_last) begin
          if ((r_frames != '0) && (w_cnt_inc == r_frames)) begin
            w_next = S_IDLE;
            w_done = 1'b1;
          end else if (w_stop) begin
            w_next = S_IDLE;
            w_done = 1'b1;
          end else if (r_per_cnt == 32'd0) begin
            w_next = S_TRIG;
            w_ovr  = 1'b1;
          end else begin
            w_next = S_WPER;
          end
        end else if (w_wd_hit) begin
          w_next = S_IDLE;
        end
      end
      S_WPER: begin
        if (w_stop) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end else if (r_per_cnt == 32'd0) begin
          w_next = S_TRIG;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register and registered control outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_trig  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_trig  <= (w_next == S_TRIG);
      r_busy  <= (w_next != S_IDLE);
      r_done  <= w_done;
    end
  end

  // Period counter: loaded on TRIG entry, so the TRIG cycle counts as period clock one
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_per_cnt <= 32'd0;
    end else if (w_next == S_TRIG) begin
      r_per_cnt <= r_period - 32'd1;
    end else if ((r_state != S_IDLE) && (r_per_cnt != 32'd0)) begin
      r_per_cnt <= r_per_cnt - 32'd1;
    end
  end

  // Stop request latch, cleared whenever the run returns to IDLE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stop_pend <= 1'b0;
    end else if (w_next == S_IDLE) begin
      r_stop_pend <= 1'b0;
    end else if (i_stop && (r_state != S_IDLE)) begin
      r_stop_pend <= 1'b1;
    end
  end

  // Frame counter and sticky overrun, both cleared by an accepted start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
    end else if (w_go) begin
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if ((r_state == S_WPKT) && i_pkt_last) r_frame_cnt <= w_cnt_inc;
      if (w_ovr) r_overrun <= 1'b1;
    end
  end

  // Config write: only in IDLE and only with a legal channel count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ch      <= 8'd8;
      r_period  <= 32'(PERIOD_MIN);
      r_frames  <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      if (i_cfg_valid) begin
        if ((r_state != S_IDLE) || (i_cfg_chnnel_num == 8'd0) ||
            (i_cfg_chnnel_num > 8'd8)) begin
          r_cfg_err <= 1'b1;
        end else begin
          r_ch     <= i_cfg_chnnel_num;
          r_frames <= i_cfg_frames;
          r_period <= (i_cfg_period < 32'(PERIOD_MIN)) ?
                      32'(PERIOD_MIN) : i_cfg_period;
        end
      end
    end
  end

`ifdef CAP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wd;
  logic            r_to;

  assign w_wd_hit = (r_wd == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog counts clocks since the seek while the packet is outstanding
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd <= '0;
      r_to <= 1'b0;
    end else begin
      if (w_next == S_TRIG) r_wd <= '0;
      else if ((r_state == S_TRIG) || (r_state == S_WPKT)) r_wd <= r_wd + WD_W'(1);
      else r_wd <= '0;
      if (w_go) r_to <= 1'b0;
      else if ((r_state == S_WPKT) && !i_pkt_last && w_wd_hit) r_to <= 1'b1;
    end
  end

  assign o_err_timeout = r_to;
`else
  assign w_wd_hit      = (TIMEOUT_CYC < 0);
  assign o_err_timeout = 1'b0;
`endif

  assign o_conv_req       = r_trig;
  assign o_cap_seek       = r_trig;
  assign o_cap_chnnel_num = r_ch;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_cfg_err        = r_cfg_err;
  assign o_overrun        = r_overrun;
  assign o_frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_ad7606_cap_sched.sv
// Bench for ad7606_cap_sched: random runs against a seek-time model.
// Define CAP_TIMEOUT_EN for the watchdog checks.
module tb_ad7606_cap_sched;

  localparam int FW   = 4;
  localparam int PMIN = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [7:0]    cfg_ch = 8'd0;
  logic [31:0]   cfg_per = 32'd0;
  logic [FW-1:0] cfg_fr = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pkt_last = 1'b0;
  logic          conv_req, seek, busy, done, cfg_err, ovr, to;
  logic [7:0]    ch_o;
  logic [FW-1:0] fcnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ad7606_cap_sched #(
    .PERIOD_MIN(PMIN), .TIMEOUT_CYC(4096), .FRAME_W(FW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_valid(cfg_valid), .i_cfg_chnnel_num(cfg_ch),
    .i_cfg_period(cfg_per), .i_cfg_frames(cfg_fr),
    .i_start(start), .i_stop(stop),
    .o_conv_req(conv_req), .o_cap_seek(seek),
    .o_cap_chnnel_num(ch_o), .i_pkt_last(pkt_last),
    .o_busy(busy), .o_done(done), .o_cfg_err(cfg_err),
    .o_overrun(ovr), .o_frame_cnt(fcnt), .o_err_timeout(to)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic advance_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_seek(input int budget, output int t, output bit ok);
    int n = 0;
    while (seek !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    ok = (seek === 1'b1);
    t = cyc;
  endtask

  task automatic cfg(input int c, input int p, input int f, input bit err);
    cfg_valid = 1'b1;
    cfg_ch = 8'(c);
    cfg_per = 32'(p);
    cfg_fr = FW'(f);
    tick();
    cfg_valid = 1'b0;
    check("cfg_err", cfg_err, err);
    tick();
    check("cfg_err_pulse", cfg_err, 0);
  endtask

  // Model: next seek = max(prev + period, pkt_last + 1); late if pkt_last
  // lands on or after the last clock of the period.
  task automatic run(input int c, input int per, input int frames,
                     input int npk, input int stop_pk, input bit busy_cfg,
                     input int dfix);
    int peff, exp_t, t, d, cnt;
    bit ok, late, last;
    peff = (per < PMIN) ? PMIN : per;
    cnt = 0;
    late = 0;
    exp_t = cyc + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start", busy, 1);
    check("ch_out", ch_o, c);
    check("fcnt_clr", fcnt, 0);
    check("ovr_clr", ovr, 0);
    for (int k = 0; k < npk; k++) begin
      wait_seek(2 * peff + 100, t, ok);
      check("seek_found", ok, 1);
      if (!ok) return;
      check("seek_time", t, exp_t);
      check("conv_req", conv_req, 1);
      if (dfix != 0) d = dfix;
      else if ($urandom_range(0, 1) == 1) d = $urandom_range(1, peff - 2);
      else d = $urandom_range(peff - 1, peff + 40);
      if (busy_cfg && k == 0) begin
        cfg_valid = 1'b1;
        cfg_ch = 8'd1;
        cfg_per = 32'd777;
        cfg_fr = FW'(1);
        tick();
        cfg_valid = 1'b0;
        check("busy_cfg_err", cfg_err, 1);
        check("busy_cfg_ch", ch_o, c);
      end
      advance_to(t + 1);
      if (k == stop_pk) begin
        stop = 1'b1;
        if (d > 1) begin
          tick();
          stop = 1'b0;
        end
      end
      advance_to(t + d);
      pkt_last = 1'b1;
      tick();
      pkt_last = 1'b0;
      stop = 1'b0;
      cnt++;
      if (d >= peff - 1) late = 1;
      last = (frames != 0 && cnt == frames) || (k == stop_pk);
      check("fcnt", fcnt, cnt % (1 << FW));
      check("overrun", ovr, late);
      check("done", done, last);
      if (last) begin
        check("busy_end", busy, 0);
        tick();
        check("done_pulse", done, 0);
        return;
      end
      exp_t = (t + peff > t + d + 1) ? t + peff : t + d + 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, t2;
    bit ok;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_seek", seek, 0);
    check("rst_ch", ch_o, 8);
    check("rst_fcnt", fcnt, 0);
    check("rst_done", done, 0);
    check("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    tick();

    // basic pacing
    cfg(8, 1000, 3, 0);
    run(8, 1000, 3, 3, -1, 0, 300);

    // rejected configs keep the previous values
    cfg(3, 500, 2, 0);
    cfg(0, 250, 1, 1);
    cfg(9, 250, 1, 1);
    check("ch_kept", ch_o, 3);
    run(3, 500, 2, 2, -1, 1, 0);

    // clamped period with late packets
    cfg(8, 50, 0, 0);
    run(8, 50, 0, 3, 2, 0, 250);

    // random runs
    for (int i = 0; i < 5; i++) begin
      int c, p, f;
      c = $urandom_range(1, 8);
      p = ($urandom_range(0, 2) == 0) ? $urandom_range(60, 199)
                                      : $urandom_range(200, 600);
      f = $urandom_range(1, 4);
      cfg(c, p, f, 0);
      run(c, p, f, f, -1, (i == 0), 0);
    end

    // continuous mode wrap, stop during last packet
    cfg(2, 200, 0, 0);
    run(2, 200, 0, 17, 16, 0, 0);

    // stop in WAIT_PER
    cfg(8, 300, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_seek(10, t, ok);
    check("wper_seek", ok, 1);
    advance_to(t + 50);
    pkt_last = 1'b1;
    tick();
    pkt_last = 1'b0;
    check("wper_nodone", done, 0);
    advance_to(t + 120);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("wper_done", done, 1);
    check("wper_busy", busy, 0);
    wait_seek(400, t2, ok);
    check("wper_noseek", ok, 0);

    // pkt_last in IDLE ignored
    pkt_last = 1'b1;
    tick();
    pkt_last = 1'b0;
    tick();
    check("idle_pkt", fcnt, 1);

    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("ss_busy", busy, 0);
    wait_seek(20, t2, ok);
    check("ss_noseek", ok, 0);

    // stop in IDLE is not remembered
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    cfg(4, 250, 2, 0);
    run(4, 250, 2, 2, -1, 0, 0);

    // async reset in WAIT_PER, then defaults
    cfg(5, 300, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_seek(10, t, ok);
    advance_to(t + 310);
    pkt_last = 1'b1;
    tick();
    pkt_last = 1'b0;
    check("pre_rst_seek", seek, 1);
    advance_to(t + 331);
    pkt_last = 1'b1;
    tick();
    pkt_last = 1'b0;
    advance_to(t + 400);
    check("pre_rst_ovr", ovr, 1);
    check("pre_rst_fcnt", fcnt, 2);
    check("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ovr", ovr, 0);
    check("arst_fcnt", fcnt, 0);
    check("arst_ch", ch_o, 8);
    check("arst_seek", seek, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run(8, PMIN, 0, 2, 1, 0, 0);

`ifdef CAP_TIMEOUT_EN
    cfg(8, 300, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_seek(10, t, ok);
    advance_to(t + 4095);
    check("to_early", to, 0);
    check("to_busy", busy, 1);
    tick();
    check("to_flag", to, 1);
    check("to_idle", busy, 0);
    check("to_nodone", done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("to_clr", to, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("to_stop_done", done, 1);
`else
    check("to_tied", to, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
